// File: rtl/svr_frame_capture_ctrl.sv
// SVR frame capture sequencer: arms on request, captures N whole frames, checks geometry and
// packs RAW10 pixels 3-per-word into a shift-register FIFO. Frame CRC built only with SVR_CAP_CRC_EN.
module svr_frame_capture_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic        fclk,
  input  logic        reset_n,
  input  logic        cap_start,
  input  logic [7:0]  cap_num_frames,
  input  logic        cap_abort,
  input  logic [15:0] exp_rows,
  input  logic [15:0] exp_cols,
  input  logic [9:0]  svr_pixel,
  input  logic        svr_pixel_valid,
  input  logic        svr_fs,
  input  logic        svr_fe,
  input  logic        svr_ls,
  input  logic        svr_le,
  output logic [31:0] out_data,
  output logic        out_sof,
  output logic        out_eol,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [7:0]  frames_captured,
  output logic        err_line_len,
  output logic        err_frame_rows,
  output logic        err_overflow,
  output logic [15:0] frame_crc
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FLUSH} state_t;
  typedef struct packed {logic sof; logic eol; logic [31:0] data;} word_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic [7:0]       n_frames_q, n_frames_d, frames_q, frames_d, frames_inc;
  logic [15:0]      exp_rows_q, exp_rows_d, exp_cols_q, exp_cols_d;
  logic             err_line_q, err_line_d, err_rows_q, err_rows_d, err_ovf_q, err_ovf_d;
  logic             in_frame_q, in_frame_d, sof_pend_q, sof_pend_d;
  logic [CNT_W-1:0] row_q, row_d, pix_q, pix_d, row_base, pix_base;
  logic [1:0]       pack_cnt_q, pack_cnt_d;
  logic [19:0]      pack_data_q, pack_data_d;
  word_t            fifo_q [FIFO_DEPTH];
  word_t            fifo_d [FIFO_DEPTH];
  word_t            push_word;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_mid, tgt;
  logic             valid_q, valid_d;
  logic             abort_take, start_take, cap_active, fs_arm, fs_cap;
  logic             pix_ev, le_ev, fe_ev, ls_ev, drained, push, pop, mark_eol;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign abort_take = cap_abort && (state_q != IDLE);
  assign start_take = cap_start && (state_q == IDLE);
  assign cap_active = (state_q == CAPTURE) && in_frame_q;
  assign fs_arm     = (state_q == ARMED) && svr_fs;
  assign fs_cap     = (state_q == CAPTURE) && svr_fs;
  assign pix_ev     = cap_active && svr_pixel_valid;
  assign le_ev      = cap_active && svr_le;
  assign fe_ev      = cap_active && svr_fe;
  assign ls_ev      = cap_active && svr_ls;
  assign drained    = (cnt_q == '0) && (pack_cnt_q == 2'd0);
  assign frames_inc = (frames_q == 8'hFF) ? frames_q : frames_q + 8'd1;
  assign pop        = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    if (abort_take) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (cap_start) state_d = ARMED;
        ARMED:   if (svr_fs) state_d = CAPTURE;
        CAPTURE: if (fe_ev && frames_inc >= n_frames_q) state_d = FLUSH;
        FLUSH:   if (drained) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_d    = (state_d != IDLE);
    done_d    = (state_q == FLUSH) && drained && !abort_take;
    aborted_d = abort_take;
  end

  always_comb begin
    n_frames_d  = n_frames_q;
    exp_rows_d  = exp_rows_q;
    exp_cols_d  = exp_cols_q;
    frames_d    = fe_ev ? frames_inc : frames_q;
    in_frame_d  = in_frame_q;
    row_base    = fs_cap ? '0 : row_q;
    row_d       = ls_ev ? sat_inc(row_base) : row_base;
    pix_base    = ls_ev ? '0 : pix_q;
    pix_d       = pix_ev ? sat_inc(pix_base) : pix_base;
    err_line_d  = err_line_q | (le_ev && (32'(pix_d) != 32'(exp_cols_q)));
    err_rows_d  = err_rows_q | (fe_ev && (32'(row_d) != 32'(exp_rows_q))) | (fs_cap && in_frame_q);
    err_ovf_d   = err_ovf_q;
    pack_cnt_d  = pack_cnt_q;
    pack_data_d = pack_data_q;
    push        = 1'b0;
    push_word   = '0;
    mark_eol    = 1'b0;
    // A word leaves the packer when full, at line end, or at frame end so FLUSH can drain.
    if (pix_ev) begin
      if (pack_cnt_q == 2'd2 || svr_le || svr_fe) begin
        push = 1'b1;
        case (pack_cnt_q)
          2'd0:    push_word.data = {2'd1, 20'd0, svr_pixel};
          2'd1:    push_word.data = {2'd2, 10'd0, svr_pixel, pack_data_q[9:0]};
          default: push_word.data = {2'd3, svr_pixel, pack_data_q};
        endcase
        push_word.eol = svr_le;
        pack_cnt_d    = 2'd0;
        pack_data_d   = '0;
      end else begin
        pack_cnt_d = pack_cnt_q + 2'd1;
        if (pack_cnt_q == 2'd0) pack_data_d[9:0] = svr_pixel;
        else                    pack_data_d[19:10] = svr_pixel;
      end
    end else if ((le_ev || fe_ev) && pack_cnt_q != 2'd0) begin
      push           = 1'b1;
      push_word.data = {pack_cnt_q, 10'd0, pack_data_q};
      push_word.eol  = le_ev;
      pack_cnt_d     = 2'd0;
      pack_data_d    = '0;
    end else if (le_ev) begin
      mark_eol = 1'b1;
    end
    push_word.sof = sof_pend_q;
    sof_pend_d    = push ? 1'b0 : sof_pend_q;
    if (fs_arm || fs_cap) begin
      sof_pend_d = 1'b1;
      in_frame_d = 1'b1;
      if (fs_arm) row_d = '0;
    end
    if (fe_ev) in_frame_d = 1'b0;

    fifo_d  = fifo_q;
    cnt_mid = cnt_q;
    if (pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) fifo_d[i] = fifo_q[i + 1];
      fifo_d[FIFO_DEPTH-1] = '0;
      cnt_mid = cnt_q - 1'b1;
    end
    tgt = cnt_mid - 1'b1;
    // Late eol goes onto the newest stored word, but never onto the word currently presented.
    if (mark_eol && cnt_mid != '0 && !(tgt == '0 && !pop)) fifo_d[tgt[AW-1:0]].eol = 1'b1;
    cnt_d = cnt_mid;
    if (push) begin
      if (cnt_mid == CW'(FIFO_DEPTH)) begin
        err_ovf_d = 1'b1;
      end else begin
        fifo_d[cnt_mid[AW-1:0]] = push_word;
        cnt_d = cnt_mid + 1'b1;
      end
    end

    if (start_take) begin
      n_frames_d = (cap_num_frames == 8'd0) ? 8'd1 : cap_num_frames;
      exp_rows_d = exp_rows;
      exp_cols_d = exp_cols;
      frames_d   = 8'd0;
      err_line_d = 1'b0;
      err_rows_d = 1'b0;
      err_ovf_d  = 1'b0;
      in_frame_d = 1'b0;
    end
    if (abort_take) begin
      frames_d    = frames_q;
      err_line_d  = err_line_q;
      err_rows_d  = err_rows_q;
      err_ovf_d   = err_ovf_q;
      in_frame_d  = 1'b0;
      sof_pend_d  = 1'b0;
      pack_cnt_d  = 2'd0;
      pack_data_d = '0;
      fifo_d      = '{default: '0};
      cnt_d       = '0;
    end
    valid_d = (cnt_d != '0);
  end

  always_ff @(posedge fclk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      n_frames_q  <= 8'd1;
      exp_rows_q  <= '0;
      exp_cols_q  <= '0;
      frames_q    <= '0;
      err_line_q  <= 1'b0;
      err_rows_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
      in_frame_q  <= 1'b0;
      sof_pend_q  <= 1'b0;
      row_q       <= '0;
      pix_q       <= '0;
      pack_cnt_q  <= '0;
      pack_data_q <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      n_frames_q  <= n_frames_d;
      exp_rows_q  <= exp_rows_d;
      exp_cols_q  <= exp_cols_d;
      frames_q    <= frames_d;
      err_line_q  <= err_line_d;
      err_rows_q  <= err_rows_d;
      err_ovf_q   <= err_ovf_d;
      in_frame_q  <= in_frame_d;
      sof_pend_q  <= sof_pend_d;
      row_q       <= row_d;
      pix_q       <= pix_d;
      pack_cnt_q  <= pack_cnt_d;
      pack_data_q <= pack_data_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      fifo_q      <= fifo_d;
    end
  end

`ifdef SVR_CAP_CRC_EN
  logic [15:0] crc_q, crc_d, crc_nx, fcrc_q, fcrc_d;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [9:0] p);
    logic [15:0] r;
    r = c;
    for (int b = 9; b >= 0; b--) r = {r[14:0], 1'b0} ^ ((r[15] ^ p[b]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction

  always_comb begin
    crc_nx = pix_ev ? crc_step(crc_q, svr_pixel) : crc_q;
    crc_d  = (fs_arm || fs_cap) ? 16'hFFFF : crc_nx;
    fcrc_d = fe_ev ? crc_nx : fcrc_q;
  end

  always_ff @(posedge fclk) begin
    if (!reset_n) begin
      crc_q  <= 16'hFFFF;
      fcrc_q <= '0;
    end else begin
      crc_q  <= crc_d;
      fcrc_q <= fcrc_d;
    end
  end

  assign frame_crc = fcrc_q;
`else
  assign frame_crc = 16'h0000;
`endif

  assign out_data        = fifo_q[0].data;
  assign out_sof         = fifo_q[0].sof;
  assign out_eol         = fifo_q[0].eol;
  assign out_valid       = valid_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign aborted         = aborted_q;
  assign frames_captured = frames_q;
  assign err_line_len    = err_line_q;
  assign err_frame_rows  = err_rows_q;
  assign err_overflow    = err_ovf_q;
endmodule
